// File: rtl/vid_layer_mixer_if.sv
// Bus bundle for vid_layer_mixer: Avalon-MM config slave, SDRAM read master and pixel FIFO push.
// Modport master is the mixer's own view of the bundle; slave is the surrounding system's view.
interface vid_layer_mixer_if #(
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 24
);
  logic [3:0]        iAVL_ADDRESS;
  logic              iAVL_READ;
  logic              iAVL_WRITE;
  logic [31:0]       iAVL_WRITE_DATA;
  logic [31:0]       oAVL_READ_DATA;
  logic              oAVL_WAIT_REQUEST;
  logic [ADDR_W-1:0] oSDRAM_ADDRESS;
  logic              oSDRAM_READ;
  logic              iSDRAM_WAIT_REQUEST;
  logic [PIX_W-1:0]  iSDRAM_READ_DATA;
  logic              iSDRAM_READ_DATA_VALID;
  logic              oPIX_START;
  logic [PIX_W-1:0]  oPIX_RGB;
  logic              oPIX_WRITE;
  logic              iPIX_FULL;

  modport master (
    input  iAVL_ADDRESS, iAVL_READ, iAVL_WRITE, iAVL_WRITE_DATA,
    output oAVL_READ_DATA, oAVL_WAIT_REQUEST,
    output oSDRAM_ADDRESS, oSDRAM_READ,
    input  iSDRAM_WAIT_REQUEST, iSDRAM_READ_DATA, iSDRAM_READ_DATA_VALID,
    output oPIX_START, oPIX_RGB, oPIX_WRITE,
    input  iPIX_FULL
  );

  modport slave (
    output iAVL_ADDRESS, iAVL_READ, iAVL_WRITE, iAVL_WRITE_DATA,
    input  oAVL_READ_DATA, oAVL_WAIT_REQUEST,
    input  oSDRAM_ADDRESS, oSDRAM_READ,
    output iSDRAM_WAIT_REQUEST, iSDRAM_READ_DATA, iSDRAM_READ_DATA_VALID,
    input  oPIX_START, oPIX_RGB, oPIX_WRITE,
    output iPIX_FULL
  );
endinterface

// File: rtl/vid_layer_mixer.sv
// Multi-layer SDRAM frame-buffer mixer, top layer first, with per-frame shadowed configuration.
// Define VID_LAYER_MIXER_COLORKEY_EN to enable colour-key fall-through to lower layers and BG.
module vid_layer_mixer #(
  parameter int NUM_LAYERS = 2,
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int PIX_W      = 16,
  parameter int ADDR_W     = 24
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  vid_layer_mixer_if.master bus
);
  localparam int NPIX  = H_RES * V_RES;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
  state_t state, state_nxt;

  logic                  ctrl_run, ctrl_cont, busy;
  logic [15:0]           frame_cnt;
  logic [PIX_W-1:0]      bg, sh_bg;
  logic [NUM_LAYERS-1:0] layer_en, sh_en;
  logic [ADDR_W-1:0]     base    [NUM_LAYERS];
  logic [ADDR_W-1:0]     sh_base [NUM_LAYERS];
`ifdef VID_LAYER_MIXER_COLORKEY_EN
  logic [PIX_W-1:0]      key     [NUM_LAYERS];
  logic [PIX_W-1:0]      sh_key  [NUM_LAYERS];
  logic                  key_hit, has_lower;
  logic [LW-1:0]         lower_ptr;
`endif
  logic [IDX_W-1:0]      pix_idx;
  logic [LW-1:0]         ptr;
  logic [PIX_W-1:0]      pix_q;
  logic [31:0]           rdata;

  logic wr_ctrl, eff_run, eff_cont, keep_going;
  logic is_last, pix_done, fall_through, start_frame;

  function automatic logic [LW-1:0] top_layer(input logic [NUM_LAYERS-1:0] en);
    top_layer = '0;
    for (int l = 0; l < NUM_LAYERS; l++)
      if (en[l]) top_layer = LW'(l);
  endfunction

  // A CTRL write landing on the last pixel decides whether the next frame runs.
  assign wr_ctrl    = bus.iAVL_WRITE && (bus.iAVL_ADDRESS == 4'd0);
  assign eff_run    = wr_ctrl ? bus.iAVL_WRITE_DATA[0] : ctrl_run;
  assign eff_cont   = wr_ctrl ? bus.iAVL_WRITE_DATA[1] : ctrl_cont;
  assign keep_going = eff_run && eff_cont;

  assign is_last     = (pix_idx == LAST_IDX);
  assign pix_done    = (state == OUT) && !bus.iPIX_FULL;
  assign start_frame = ((state == IDLE) && ctrl_run) || (pix_done && is_last && keep_going);

`ifdef VID_LAYER_MIXER_COLORKEY_EN
  assign key_hit = (bus.iSDRAM_READ_DATA == sh_key[ptr]);

  always_comb begin
    has_lower = 1'b0;
    lower_ptr = '0;
    for (int l = 0; l < NUM_LAYERS; l++)
      if (sh_en[l] && (LW'(l) < ptr)) begin
        has_lower = 1'b1;
        lower_ptr = LW'(l);
      end
  end

  assign fall_through = key_hit && has_lower;
`else
  assign fall_through = 1'b0;
`endif

  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ctrl_run) state_nxt = (|layer_en) ? REQ : OUT;
      REQ:  if (!bus.iSDRAM_WAIT_REQUEST) state_nxt = WAIT;
      WAIT: if (bus.iSDRAM_READ_DATA_VALID) state_nxt = fall_through ? REQ : OUT;
      OUT: begin
        if (!bus.iPIX_FULL) begin
          if (!is_last)        state_nxt = (|sh_en) ? REQ : OUT;
          else if (keep_going) state_nxt = (|layer_en) ? REQ : OUT;
          else                 state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      ctrl_run  <= 1'b0;
      ctrl_cont <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      bg        <= '0;
      sh_bg     <= '0;
      layer_en  <= '0;
      sh_en     <= '0;
      pix_idx   <= '0;
      ptr       <= '0;
      pix_q     <= '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        base[l]    <= '0;
        sh_base[l] <= '0;
`ifdef VID_LAYER_MIXER_COLORKEY_EN
        key[l]     <= '0;
        sh_key[l]  <= '0;
`endif
      end
    end else begin
      if (start_frame) begin
        sh_bg   <= bg;
        sh_en   <= layer_en;
        for (int l = 0; l < NUM_LAYERS; l++) begin
          sh_base[l] <= base[l];
`ifdef VID_LAYER_MIXER_COLORKEY_EN
          sh_key[l]  <= key[l];
`endif
        end
        pix_idx <= '0;
        ptr     <= top_layer(layer_en);
        pix_q   <= bg;
        busy    <= 1'b1;
      end

      case (state)
        WAIT: begin
          if (bus.iSDRAM_READ_DATA_VALID) begin
`ifdef VID_LAYER_MIXER_COLORKEY_EN
            if (fall_through) ptr   <= lower_ptr;
            else              pix_q <= key_hit ? sh_bg : bus.iSDRAM_READ_DATA;
`else
            pix_q <= bus.iSDRAM_READ_DATA;
`endif
          end
        end
        OUT: begin
          if (!bus.iPIX_FULL) begin
            if (!is_last) begin
              pix_idx <= pix_idx + 1'b1;
              ptr     <= top_layer(sh_en);
              if (~|sh_en) pix_q <= sh_bg;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
              if (!keep_going) begin
                busy     <= 1'b0;
                ctrl_run <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase

      // Register writes come last so a same-cycle CTRL write overrides the RUN clear.
      if (bus.iAVL_WRITE) begin
        case (bus.iAVL_ADDRESS)
          4'd0: begin
            ctrl_run  <= bus.iAVL_WRITE_DATA[0];
            ctrl_cont <= bus.iAVL_WRITE_DATA[1];
          end
          4'd2: bg       <= bus.iAVL_WRITE_DATA[PIX_W-1:0];
          4'd3: layer_en <= bus.iAVL_WRITE_DATA[NUM_LAYERS-1:0];
          default: ;
        endcase
        for (int l = 0; l < NUM_LAYERS; l++) begin
          if (bus.iAVL_ADDRESS == 4'(4 + 2*l)) base[l] <= bus.iAVL_WRITE_DATA[ADDR_W-1:0];
`ifdef VID_LAYER_MIXER_COLORKEY_EN
          if (bus.iAVL_ADDRESS == 4'(5 + 2*l)) key[l]  <= bus.iAVL_WRITE_DATA[PIX_W-1:0];
`endif
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.iAVL_READ) begin
      case (bus.iAVL_ADDRESS)
        4'd0: rdata[1:0]            = {ctrl_cont, ctrl_run};
        4'd1: rdata                 = {frame_cnt, 15'd0, busy};
        4'd2: rdata[PIX_W-1:0]      = bg;
        4'd3: rdata[NUM_LAYERS-1:0] = layer_en;
        default: ;
      endcase
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (bus.iAVL_ADDRESS == 4'(4 + 2*l)) rdata[ADDR_W-1:0] = base[l];
`ifdef VID_LAYER_MIXER_COLORKEY_EN
        if (bus.iAVL_ADDRESS == 4'(5 + 2*l)) rdata[PIX_W-1:0]  = key[l];
`endif
      end
    end
  end

  assign bus.oAVL_READ_DATA    = rdata;
  assign bus.oAVL_WAIT_REQUEST = 1'b0;
  assign bus.oSDRAM_READ       = (state == REQ);
  assign bus.oSDRAM_ADDRESS    = (state == REQ) ? (sh_base[ptr] + ADDR_W'(pix_idx)) : '0;
  assign bus.oPIX_WRITE        = pix_done;
  assign bus.oPIX_START        = pix_done && (pix_idx == '0);
  assign bus.oPIX_RGB          = pix_q;
endmodule

// File: tb/tb_vid_layer_mixer.sv
// Directed bench for vid_layer_mixer: 4x2 frame, two layers, 2-cycle-latency SDRAM model.
module tb_vid_layer_mixer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vid_layer_mixer_if #(.PIX_W(16), .ADDR_W(24)) bus ();

  vid_layer_mixer #(
    .NUM_LAYERS(2), .H_RES(4), .V_RES(2), .PIX_W(16), .ADDR_W(24)
  ) dut (
    .iCLOCK(clk),
    .iRESET(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [int unsigned];
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [15:0] d1 = '0,   d2 = '0;
  logic        sd_wait = 1'b0;
  logic        pix_full = 1'b0;

  logic [15:0] got_rgb[$];
  logic        got_start[$];
  logic [23:0] got_addr[$];

  function automatic logic [15:0] rd_mem(input logic [23:0] a);
    int unsigned k;
    k = int'(a);
    return mem.exists(k) ? mem[k] : 16'h0000;
  endfunction

  // SDRAM: data valid two edges after the accepting edge; not cleared by DUT reset.
  always @(posedge clk) begin
    v1 <= bus.oSDRAM_READ && !bus.iSDRAM_WAIT_REQUEST;
    d1 <= rd_mem(bus.oSDRAM_ADDRESS);
    v2 <= v1;
    d2 <= d1;
  end
  assign bus.iSDRAM_READ_DATA_VALID = v2;
  assign bus.iSDRAM_READ_DATA       = d2;
  assign bus.iSDRAM_WAIT_REQUEST    = sd_wait;
  assign bus.iPIX_FULL              = pix_full;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.oPIX_WRITE) begin
        got_rgb.push_back(bus.oPIX_RGB);
        got_start.push_back(bus.oPIX_START);
      end
      if (bus.oSDRAM_READ && !bus.iSDRAM_WAIT_REQUEST) got_addr.push_back(bus.oSDRAM_ADDRESS);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic avl_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.iAVL_ADDRESS    = a;
    bus.iAVL_WRITE_DATA = d;
    bus.iAVL_WRITE      = 1'b1;
    @(posedge clk); #1;
    bus.iAVL_WRITE      = 1'b0;
  endtask

  task automatic avl_read(input logic [3:0] a, output logic [31:0] d);
    bus.iAVL_ADDRESS = a;
    bus.iAVL_READ    = 1'b1;
    #1;
    d = bus.oAVL_READ_DATA;
    bus.iAVL_READ    = 1'b0;
  endtask

  task automatic clear_queues();
    got_rgb.delete();
    got_start.delete();
    got_addr.delete();
  endtask

  task automatic wait_pixels(input int n);
    for (int i = 0; i < 3000 && got_rgb.size() < n; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.oSDRAM_READ, bus.oPIX_WRITE, bus.oPIX_START, bus.oPIX_RGB, bus.oSDRAM_ADDRESS} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b wr=%b st=%b rgb=%h addr=%h required all 0",
               bus.oSDRAM_READ, bus.oPIX_WRITE, bus.oPIX_START, bus.oPIX_RGB, bus.oSDRAM_ADDRESS);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    avl_read(4'd1, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required %h", rd, 32'h0); end
    avl_read(4'd0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h required %h", rd, 32'h0); end
    checks++;
    if (bus.oAVL_WAIT_REQUEST !== 1'b0) begin
      errors++; $display("FAIL avl_wait: got %b required 0", bus.oAVL_WAIT_REQUEST);
    end
  endtask

  task automatic test_single_layer();
    logic [31:0] rd;
    clear_queues();
    for (int i = 0; i < 8; i++) mem[32'h100 + i] = 16'(i);
    avl_write(4'd3, 32'h2);
    avl_write(4'd6, 32'h100);
    avl_write(4'd0, 32'h1);
    checks++;
    if (bus.oSDRAM_READ !== 1'b0) begin errors++; $display("FAIL run_latency_e1: read=%b required 0", bus.oSDRAM_READ); end
    @(posedge clk); #1;
    checks++;
    if (bus.oSDRAM_READ !== 1'b1) begin errors++; $display("FAIL run_latency_e2: read=%b required 1", bus.oSDRAM_READ); end
    checks++;
    if (bus.oSDRAM_ADDRESS !== 24'h100) begin
      errors++; $display("FAIL first_addr: got %h required %h", bus.oSDRAM_ADDRESS, 24'h100);
    end
    wait_pixels(8);
    checks++;
    if (got_rgb.size() !== 8) begin errors++; $display("FAIL single_count: got %0d required 8", got_rgb.size()); end
    for (int i = 0; i < got_rgb.size() && i < 8; i++) begin
      checks++;
      if (got_rgb[i] !== 16'(i) || got_start[i] !== (i == 0)) begin
        errors++;
        $display("FAIL single_pix[%0d]: rgb=%h start=%b required rgb=%h start=%b", i, got_rgb[i], got_start[i], 16'(i), (i == 0));
      end
    end
    checks++;
    if (got_addr.size() !== 8) begin errors++; $display("FAIL single_reads: got %0d required 8", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < 8; i++) begin
      checks++;
      if (got_addr[i] !== 24'(32'h100 + i)) begin
        errors++; $display("FAIL single_addr[%0d]: got %h required %h", i, got_addr[i], 24'(32'h100 + i));
      end
    end
    avl_read(4'd1, rd);
    checks++;
    if (rd !== 32'h0001_0000) begin errors++; $display("FAIL single_status: got %h required %h", rd, 32'h0001_0000); end
    avl_read(4'd0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL single_run_clear: got %h required 0", rd); end
  endtask

  task automatic test_colour_key();
    logic [31:0] rd;
    logic [15:0] exp_pix;
    logic [31:0] exp_key;
    int          n_addr;
    clear_queues();
    for (int i = 0; i < 8; i++) begin
      mem[32'h100 + i] = 16'hF81F;
      mem[32'h200 + i] = 16'h1234;
    end
    avl_write(4'd3, 32'h3);
    avl_write(4'd4, 32'h200);
    avl_write(4'd7, 32'hF81F);
`ifdef VID_LAYER_MIXER_COLORKEY_EN
    exp_pix = 16'h1234; n_addr = 16; exp_key = 32'hF81F;
`else
    exp_pix = 16'hF81F; n_addr = 8;  exp_key = 32'h0;
`endif
    avl_read(4'd7, rd);
    checks++;
    if (rd !== exp_key) begin errors++; $display("FAIL key1_read: got %h required %h", rd, exp_key); end
    avl_write(4'd0, 32'h1);
    wait_pixels(8);
    checks++;
    if (got_rgb.size() !== 8) begin errors++; $display("FAIL key_count: got %0d required 8", got_rgb.size()); end
    for (int i = 0; i < got_rgb.size() && i < 8; i++) begin
      checks++;
      if (got_rgb[i] !== exp_pix) begin errors++; $display("FAIL key_pix[%0d]: got %h required %h", i, got_rgb[i], exp_pix); end
    end
    checks++;
    if (got_addr.size() !== n_addr) begin errors++; $display("FAIL key_reads: got %0d required %0d", got_addr.size(), n_addr); end
    for (int i = 0; i < got_addr.size() && i < n_addr; i++) begin
      logic [23:0] ea;
      if (n_addr == 16) ea = (i % 2 == 0) ? 24'(32'h100 + i/2) : 24'(32'h200 + i/2);
      else              ea = 24'(32'h100 + i);
      checks++;
      if (got_addr[i] !== ea) begin errors++; $display("FAIL key_addr[%0d]: got %h required %h", i, got_addr[i], ea); end
    end
  endtask

  task automatic test_background();
    logic [15:0] exp_pix;
    int          n_addr;
    clear_queues();
    avl_write(4'd2, 32'h07E0);
    avl_write(4'd5, 32'h1234);
`ifdef VID_LAYER_MIXER_COLORKEY_EN
    exp_pix = 16'h07E0; n_addr = 16;
`else
    exp_pix = 16'hF81F; n_addr = 8;
`endif
    avl_write(4'd0, 32'h1);
    wait_pixels(8);
    checks++;
    if (got_rgb.size() !== 8) begin errors++; $display("FAIL bg_count: got %0d required 8", got_rgb.size()); end
    for (int i = 0; i < got_rgb.size() && i < 8; i++) begin
      checks++;
      if (got_rgb[i] !== exp_pix) begin errors++; $display("FAIL bg_pix[%0d]: got %h required %h", i, got_rgb[i], exp_pix); end
    end
    checks++;
    if (got_addr.size() !== n_addr) begin errors++; $display("FAIL bg_reads: got %0d required %0d", got_addr.size(), n_addr); end
  endtask

  task automatic test_stall();
    logic        ok;
    logic [23:0] held_addr;
    clear_queues();
    for (int i = 0; i < 8; i++) mem[32'h100 + i] = 16'(16'h10 + i);
    avl_write(4'd3, 32'h2);
    avl_write(4'd0, 32'h1);
    for (int i = 0; i < 500 && got_rgb.size() < 3; i++) begin @(posedge clk); #1; end
    pix_full = 1'b1;
    for (int i = 0; i < 500 && bus.oPIX_RGB !== 16'h13; i++) begin @(posedge clk); #1; end
    ok = (bus.oPIX_RGB === 16'h13);
    for (int i = 0; i < 5; i++) begin
      if (bus.oPIX_WRITE !== 1'b0 || bus.oPIX_RGB !== 16'h13) ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL full_hold: rgb=%h write=%b required rgb=0013 write=0", bus.oPIX_RGB, bus.oPIX_WRITE); end
    pix_full = 1'b0;
    for (int i = 0; i < 500 && got_rgb.size() < 6; i++) begin @(posedge clk); #1; end
    sd_wait = 1'b1;
    for (int i = 0; i < 500 && bus.oSDRAM_READ !== 1'b1; i++) begin @(posedge clk); #1; end
    held_addr = bus.oSDRAM_ADDRESS;
    ok = (bus.oSDRAM_READ === 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.oSDRAM_READ !== 1'b1 || bus.oSDRAM_ADDRESS !== held_addr) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_hold: read=%b addr=%h required read=1 addr=%h", bus.oSDRAM_READ, bus.oSDRAM_ADDRESS, held_addr); end
    sd_wait = 1'b0;
    wait_pixels(8);
    checks++;
    if (got_rgb.size() !== 8 || got_addr.size() !== 8) begin
      errors++; $display("FAIL stall_count: pixels=%0d reads=%0d required 8 and 8", got_rgb.size(), got_addr.size());
    end
    for (int i = 0; i < got_rgb.size() && i < 8; i++) begin
      checks++;
      if (got_rgb[i] !== 16'(16'h10 + i) || got_addr[i] !== 24'(32'h100 + i)) begin
        errors++; $display("FAIL stall_pix[%0d]: rgb=%h addr=%h required rgb=%h addr=%h", i, got_rgb[i], got_addr[i], 16'(16'h10 + i), 24'(32'h100 + i));
      end
    end
  endtask

  task automatic test_continuous();
    logic [31:0] rd;
    clear_queues();
    for (int i = 0; i < 8; i++) begin
      mem[32'h100 + i] = 16'(16'h20 + i);
      mem[32'h300 + i] = 16'(16'h40 + i);
    end
    avl_write(4'd6, 32'h100);
    avl_write(4'd0, 32'h3);
    for (int i = 0; i < 500 && got_rgb.size() < 2; i++) begin @(posedge clk); #1; end
    avl_write(4'd6, 32'h300);
    for (int i = 0; i < 1000 && got_rgb.size() < 10; i++) begin @(posedge clk); #1; end
    avl_write(4'd0, 32'h0);
    wait_pixels(16);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (got_rgb.size() !== 16) begin errors++; $display("FAIL cont_count: got %0d required 16", got_rgb.size()); end
    for (int i = 0; i < got_rgb.size() && i < 16; i++) begin
      logic [15:0] ep;
      logic [23:0] ea;
      ep = (i < 8) ? 16'(16'h20 + i) : 16'(16'h40 + i - 8);
      ea = (i < 8) ? 24'(32'h100 + i) : 24'(32'h300 + i - 8);
      checks++;
      if (got_rgb[i] !== ep || got_start[i] !== (i % 8 == 0) || got_addr[i] !== ea) begin
        errors++;
        $display("FAIL cont_pix[%0d]: rgb=%h start=%b addr=%h required rgb=%h start=%b addr=%h",
                 i, got_rgb[i], got_start[i], got_addr[i], ep, (i % 8 == 0), ea);
      end
    end
    avl_read(4'd1, rd);
    checks++;
    if (rd !== 32'h0006_0000) begin errors++; $display("FAIL cont_status: got %h required %h", rd, 32'h0006_0000); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    logic        ok;
    clear_queues();
    avl_write(4'd6, 32'h100);
    avl_write(4'd0, 32'h1);
    for (int i = 0; i < 500 && bus.oSDRAM_READ !== 1'b1; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    bus.iAVL_ADDRESS = 4'd6;
    bus.iAVL_READ    = 1'b1;
    #1;
    checks++;
    if ({bus.oSDRAM_READ, bus.oPIX_WRITE, bus.oPIX_START, bus.oPIX_RGB, bus.oSDRAM_ADDRESS, bus.oAVL_READ_DATA} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rd=%b wr=%b st=%b rgb=%h addr=%h avl=%h required all 0",
               bus.oSDRAM_READ, bus.oPIX_WRITE, bus.oPIX_START, bus.oPIX_RGB, bus.oSDRAM_ADDRESS, bus.oAVL_READ_DATA);
    end
    bus.iAVL_READ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.oSDRAM_READ !== 1'b0 || bus.oPIX_WRITE !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_quiet: read=%b write=%b required 0 after reset", bus.oSDRAM_READ, bus.oPIX_WRITE); end
    avl_read(4'd3, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL midreset_regs: layer_en=%h required 0", rd); end
    clear_queues();
    avl_write(4'd3, 32'h2);
    avl_write(4'd6, 32'h100);
    avl_write(4'd0, 32'h1);
    wait_pixels(8);
    checks++;
    if (got_rgb.size() !== 8 || got_addr.size() < 1) begin
      errors++; $display("FAIL restart_count: pixels=%0d reads=%0d required 8 and >=1", got_rgb.size(), got_addr.size());
    end else begin
      checks++;
      if (got_addr[0] !== 24'h100 || got_rgb[0] !== 16'h20 || got_start[0] !== 1'b1) begin
        errors++; $display("FAIL restart_first: addr=%h rgb=%h start=%b required addr=000100 rgb=0020 start=1", got_addr[0], got_rgb[0], got_start[0]);
      end
      checks++;
      if (got_rgb[7] !== 16'h27) begin errors++; $display("FAIL restart_last: got %h required 0027", got_rgb[7]); end
    end
    avl_read(4'd1, rd);
    checks++;
    if (rd !== 32'h0001_0000) begin errors++; $display("FAIL restart_status: got %h required %h", rd, 32'h0001_0000); end
  endtask

  initial begin
    bus.iAVL_ADDRESS    = '0;
    bus.iAVL_READ       = 1'b0;
    bus.iAVL_WRITE      = 1'b0;
    bus.iAVL_WRITE_DATA = '0;
    test_reset();
    test_single_layer();
    test_colour_key();
    test_background();
    test_stall();
    test_continuous();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
